// File: rtl/dcache_pkg.sv
// Shared types and sizing for the data-side cache responder.
// Address slicing: [1:0] byte offset, [IDX_W+1:2] index, the rest tag.
package dcache_pkg;
   typedef enum logic [1:0] {IDLE, RDMISS, WRTHRU} state_t;

   localparam int DEF_IDX_W  = 4;
   localparam int DEF_ADDR_W = 32;

   function automatic int tagW(input int addrW, input int idxW);
      return addrW - idxW - 2;
   endfunction
endpackage

// File: rtl/dcache_responder_if.sv
// Backing-memory bus: the cache is the master, the memory model is the slave.
interface dcache_responder_if #(parameter int ADDR_W = 32);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_ready, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_ready, mem_rdata);
endinterface

// File: rtl/dcache_array.sv
// Direct-mapped line storage: one write port, combinational read by index.
// Reset clears only the valid bits; tag/data contents are don't-care until filled.
module dcache_array #(
   parameter int IDX_W = 4,
   parameter int TAG_W = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] idx,
   input  logic             we,
   input  logic [TAG_W-1:0] wTag,
   input  logic [31:0]      wData,
   output logic             lineValid,
   output logic [TAG_W-1:0] lineTag,
   output logic [31:0]      lineData
);
   localparam int LINES = 2 ** IDX_W;

   logic [LINES-1:0]            valid;
   logic [LINES-1:0][TAG_W-1:0] tags;
   logic [LINES-1:0][31:0]      data;

   always_ff @(posedge clk) begin
      if (reset)   valid      <= '0;
      else if (we) valid[idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tags[idx] <= wTag;
         data[idx] <= wData;
      end
   end

   assign lineValid = valid[idx];
   assign lineTag   = tags[idx];
   assign lineData  = data[idx];
endmodule

// File: rtl/dcache_responder.sv
// M-stage data cache: write-through, write-allocate, one word per line.
// Hits return combinationally; misses and stores stall until mem_ready.
module dcache_responder import dcache_pkg::*; #(
   parameter int IDX_W  = DEF_IDX_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memreadM,
   input  logic              memwriteM,
   input  logic [ADDR_W-1:0] addrM,
   input  logic [31:0]       writedataM,
   output logic [31:0]       readdataM,
   output logic              stallM,
   dcache_responder_if.master mem
);
   localparam int TAG_W = tagW(ADDR_W, IDX_W);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              lineValid;
   logic [TAG_W-1:0]  lineTag;
   logic [31:0]       lineData;
   logic              hit, isStore, isLoad, done, fillWe;
   logic [31:0]       fillData;

   assign idx     = addrM[IDX_W+1:2];
   assign tag     = addrM[ADDR_W-1:IDX_W+2];
   assign hit     = lineValid && (lineTag == tag);
   assign isStore = memwriteM;
   assign isLoad  = memreadM && !memwriteM;

   // M-stage inputs are frozen by stallM, so addrM/writedataM still describe
   // the outstanding access when the memory completes.
   assign done     = (state != IDLE) && mem.mem_ready;
   assign fillWe   = done && !reset;
   assign fillData = (state == RDMISS) ? mem.mem_rdata : writedataM;

   dcache_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) uArray (
      .clk       (clk),
      .reset     (reset),
      .idx       (idx),
      .we        (fillWe),
      .wTag      (tag),
      .wData     (fillData),
      .lineValid (lineValid),
      .lineTag   (lineTag),
      .lineData  (lineData)
   );

   always_comb begin
      stallM    = 1'b0;
      readdataM = lineData;
      if (!reset) begin
         case (state)
            IDLE:   stallM = isStore || (isLoad && !hit);
            RDMISS: begin
               stallM = !mem.mem_ready;
               if (mem.mem_ready) readdataM = mem.mem_rdata;
            end
            WRTHRU: stallM = !mem.mem_ready;
            default: stallM = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (isStore) begin
                  state         <= WRTHRU;
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= 1'b1;
                  mem.mem_addr  <= addrM & ~ADDR_W'(3);
                  mem.mem_wdata <= writedataM;
               end else if (isLoad && !hit) begin
                  state        <= RDMISS;
                  mem.mem_req  <= 1'b1;
                  mem.mem_we   <= 1'b0;
                  mem.mem_addr <= addrM & ~ADDR_W'(3);
               end
            end
            RDMISS, WRTHRU: begin
               if (mem.mem_ready) begin
                  state       <= IDLE;
                  mem.mem_req <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
